// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file.
package regfile_pkg;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_ZERO_REG = 0;
  localparam int RF_MIN_PORT = 1;
  localparam int RF_MAX_NRD  = 4;
  localparam int RF_MAX_NWR  = 2;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by reserve,
// cleared by a committed write. A reserve wins over a same-cycle write so
// that the newer producer keeps ownership. Register 0 is never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NRD    = 2,
  parameter int NWR    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] ra,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] wa,
  input  logic                  rsv,
  input  logic [ADDR_W-1:0]     rsv_a,
  output logic [NRD-1:0]        rbusy
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy, busy_nxt;

  // Release on committed writes first, then apply the reservation on top.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWR; j++)
      if (we[j] && wa[j*ADDR_W +: ADDR_W] != ADDR_W'(RF_ZERO_REG))
        busy_nxt[wa[j*ADDR_W +: ADDR_W]] = 1'b0;
    if (rsv && rsv_a != ADDR_W'(RF_ZERO_REG))
      busy_nxt[rsv_a] = 1'b1;
    busy_nxt[RF_ZERO_REG] = 1'b0;
  end

  // Busy vector register; reset drops every outstanding reservation.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // Per-port lookup of registered busy state.
  always_comb begin
    rbusy = '0;
    for (int k = 0; k < NRD; k++)
      rbusy[k] = busy[ra[k*ADDR_W +: ADDR_W]];
  end
endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with hardwired zero register,
// write-port priority (highest index wins) and a RAW-hazard scoreboard.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-through forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NRD    = 2,
  parameter int NWR    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rbusy,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] wa,
  input  logic [NWR*DATA_W-1:0] wd,
  input  logic                  rsv,
  input  logic [ADDR_W-1:0]     rsv_a
);
  localparam int DEPTH = 1 << ADDR_W;

  generate
    if (NRD < RF_MIN_PORT || NRD > RF_MAX_NRD) begin : g_bad_nrd
      $error("regfile_mp: NRD must be in 1..4");
    end
    if (NWR < RF_MIN_PORT || NWR > RF_MAX_NWR) begin : g_bad_nwr
      $error("regfile_mp: NWR must be in 1..2");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];
  logic [NRD-1:0]    sb_busy;

  // Data array; ports applied in index order so the highest port wins a
  // same-address collision. Register 0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (we[j] && wa[j*ADDR_W +: ADDR_W] != ADDR_W'(RF_ZERO_REG))
          mem[wa[j*ADDR_W +: ADDR_W]] <= wd[j*DATA_W +: DATA_W];
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD),
    .NWR    (NWR)
  ) u_sb (
    .clk   (clk),
    .rst   (rst),
    .ra    (ra),
    .we    (we),
    .wa    (wa),
    .rsv   (rsv),
    .rsv_a (rsv_a),
    .rbusy (sb_busy)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_k;
    logic [DATA_W-1:0] rd_k;
    logic              rbusy_k;

    assign ra_k = ra[k*ADDR_W +: ADDR_W];

    // Read mux: zero register forced to 0, optional write-through forwarding.
    always_comb begin
      rd_k    = (ra_k == ADDR_W'(RF_ZERO_REG)) ? '0 : mem[ra_k];
      rbusy_k = sb_busy[k];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++)
        if (we[j] && ra_k != ADDR_W'(RF_ZERO_REG) && wa[j*ADDR_W +: ADDR_W] == ra_k) begin
          rd_k    = wd[j*DATA_W +: DATA_W];
          rbusy_k = rsv && (rsv_a == ra_k);
        end
`endif
    end

    assign rd[k*DATA_W +: DATA_W] = rd_k;
    assign rbusy[k]               = rbusy_k;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NRD=4, NWR=2): directed test-plan
// cases followed by randomized traffic against an array-based model.
module tb_regfile_mp;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 4;
  localparam int NWR = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NRD*AW-1:0]  ra;
  logic [NRD*DW-1:0]  rd;
  logic [NRD-1:0]     rbusy;
  logic [NWR-1:0]     we;
  logic [NWR*AW-1:0]  wa;
  logic [NWR*DW-1:0]  wd;
  logic               rsv;
  logic [AW-1:0]      rsv_a;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] m_reg  [32];
  bit            m_busy [32];

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .rsv(rsv), .rsv_a(rsv_a)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model read: register contents, plus forwarding when the bypass is built in.
  function automatic logic [DW-1:0] exp_rd(input int k);
    int a = int'(ra[k*AW +: AW]);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = m_reg[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NWR; j++)
      if (we[j] && int'(wa[j*AW +: AW]) == a) v = wd[j*DW +: DW];
`endif
    return v;
  endfunction

  function automatic bit exp_busy(input int k);
    int a = int'(ra[k*AW +: AW]);
    bit b;
    if (a == 0) return 1'b0;
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NWR; j++)
      if (we[j] && int'(wa[j*AW +: AW]) == a) b = rsv && (int'(rsv_a) == a);
`endif
    return b;
  endfunction

  task automatic check_all();
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("rd%0d", k), 64'(rd[k*DW +: DW]), 64'(exp_rd(k)));
      chk($sformatf("rbusy%0d", k), 64'(rbusy[k]), 64'(exp_busy(k)));
    end
  endtask

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
      return;
    end
    for (int j = 0; j < NWR; j++)
      if (we[j] && wa[j*AW +: AW] != 0) begin
        m_reg[wa[j*AW +: AW]]  = wd[j*DW +: DW];
        m_busy[wa[j*AW +: AW]] = 1'b0;
      end
    if (rsv && rsv_a != 0) m_busy[rsv_a] = 1'b1;
  endtask

  // Check outputs mid-cycle, then commit the current inputs at the edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we = '0; wa = '0; wd = '0; rsv = 1'b0; rsv_a = '0;
  endtask

  task automatic set_ra(input int p, input int a);
    ra[p*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    we[p] = 1'b1; wa[p*AW +: AW] = AW'(a); wd[p*DW +: DW] = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_reg[i] = 'x; m_busy[i] = 1'b0; end
    idle(); ra = '0;
    rst = 1'b1;
    @(posedge clk); model_update(); #1;
    idle();
    for (int k = 0; k < NRD; k++) set_ra(k, k + 4);
    #1;
    for (int k = 0; k < NRD; k++) chk("reset_rd", 64'(rd[k*DW +: DW]), 64'd0);
    chk("reset_rbusy", 64'(rbusy), 64'd0);

    // Reset clears written data
    wr(0, 5, 32'hDEADBEEF); cycle(); idle(); set_ra(0, 5); #1;
    chk("wr_r5", 64'(rd[DW-1:0]), 64'hDEADBEEF);
    rsv = 1'b1; rsv_a = 5'd6; cycle(); idle();
    rst = 1'b1; cycle(); idle(); set_ra(1, 6); #1;
    chk("rst_r5", 64'(rd[DW-1:0]), 64'd0);
    chk("rst_rbusy", 64'(rbusy), 64'd0);

    // Zero register
    wr(0, 0, 32'hFFFFFFFF); cycle(); idle();
    rsv = 1'b1; rsv_a = '0; cycle(); idle();
    set_ra(0, 0); #1;
    chk("zero_rd", 64'(rd[DW-1:0]), 64'd0);
    chk("zero_busy", 64'(rbusy[0]), 64'd0);

    // Same-address write conflict: port 1 wins
    wr(0, 7, 32'h11111111); wr(1, 7, 32'h22222222); cycle(); idle();
    set_ra(0, 7); #1;
    chk("conflict_r7", 64'(rd[DW-1:0]), 64'h22222222);

    // Scoreboard reserve/release
    set_ra(0, 3);
    rsv = 1'b1; rsv_a = 5'd3; cycle(); idle(); #1;
    chk("sb_rsv_r3", 64'(rbusy[0]), 64'd1);
    cycle(); cycle();
    wr(0, 3, 32'h1234); cycle(); idle(); #1;
    chk("sb_wr_rd", 64'(rd[DW-1:0]), 64'h1234);
    chk("sb_wr_busy", 64'(rbusy[0]), 64'd0);
    wr(1, 3, 32'h5678); rsv = 1'b1; rsv_a = 5'd3; cycle(); idle(); #1;
    chk("sb_both_busy", 64'(rbusy[0]), 64'd1);
    chk("sb_both_rd", 64'(rd[DW-1:0]), 64'h5678);
    wr(0, 3, 32'h0); cycle(); idle();

    // Forwarding behaviour on a reserved register
    rsv = 1'b1; rsv_a = 5'd9; cycle(); idle();
    set_ra(0, 9); wr(0, 9, 32'hCAFEF00D); #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd", 64'(rd[DW-1:0]), 64'hCAFEF00D);
    chk("byp_busy", 64'(rbusy[0]), 64'd0);
`else
    chk("nobyp_rd", 64'(rd[DW-1:0]), 64'd0);
    chk("nobyp_busy", 64'(rbusy[0]), 64'd1);
`endif
    cycle(); idle();

    // Multi-read
    wr(0, 1, 32'd1); wr(1, 2, 32'd2); cycle(); idle();
    wr(0, 3, 32'd3); cycle(); idle();
    set_ra(3, 1); set_ra(2, 2); set_ra(1, 3); set_ra(0, 1); #1;
    chk("mr_p3", 64'(rd[3*DW +: DW]), 64'd1);
    chk("mr_p2", 64'(rd[2*DW +: DW]), 64'd2);
    chk("mr_p1", 64'(rd[1*DW +: DW]), 64'd3);
    chk("mr_p0", 64'(rd[0*DW +: DW]), 64'd1);

    // Randomized traffic on a narrow address range to force collisions
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 59) == 0);
      we    = NWR'($urandom);
      for (int j = 0; j < NWR; j++) begin
        wa[j*AW +: AW] = AW'($urandom_range(0, 7));
        wd[j*DW +: DW] = $urandom;
      end
      rsv   = ($urandom_range(0, 2) == 0);
      rsv_a = AW'($urandom_range(0, 7));
      for (int k = 0; k < NRD; k++) set_ra(k, $urandom_range(0, 7));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
